// File: rtl/s_spi_slave.sv
// s_spi_slave: mode-0 SPI slave with oversampled pins, rx byte buffer and preloaded tx buffer.
module s_spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_on_1,
    input  logic                  SCLK_SLAVE,
    input  logic                  SS_N_SLAVE,
    input  logic                  MOSI_SLAVE,
    output logic                  MISO_SLAVE,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic [AW-1:0]         rx_index,
    output logic                  is_selected,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  tx_wr_en,
    input  logic [AW-1:0]         tx_wr_addr,
    input  logic [DATA_WIDTH-1:0] tx_wr_data
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [2:0] sclk_q, ss_q, mosi_q;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d, rx_data_q, rx_data_d, rd_data_q, rx_byte;
    logic [AW-1:0] tx_index_q, tx_index_d, rx_index_q, rx_index_d;
    logic rx_valid_q, rx_valid_d, reload_q, reload_d, rx_we;
    logic [DATA_WIDTH-1:0] rx_buf_q [DEPTH];
    // Power-up greeting; reset deliberately leaves this buffer untouched.
    logic [DATA_WIDTH-1:0] tx_buf_q [DEPTH] = '{0: DATA_WIDTH'("S"), 1: DATA_WIDTH'("L"),
        2: DATA_WIDTH'("A"), 3: DATA_WIDTH'("V"), 4: DATA_WIDTH'("E"), default: '0};
    wire sclk_rise = sclk_q[1] & ~sclk_q[2];
    wire sclk_fall = ~sclk_q[1] & sclk_q[2];
    wire ss_fall = ~ss_q[1] & ss_q[2];
    wire ss_rise = ss_q[1] & ~ss_q[2];
    wire last_bit = bit_cnt_q == BW'(DATA_WIDTH - 1);

    // Synchronizers keep tracking the pins through reset so a held-low SS_N is not a new edge.
    always_ff @(posedge clk) begin
        sclk_q <= {sclk_q[1:0], SCLK_SLAVE};
        ss_q   <= {ss_q[1:0], SS_N_SLAVE};
        mosi_q <= {mosi_q[1:0], MOSI_SLAVE};
    end

    always_ff @(posedge clk) begin
        if (reset_on_1) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_index_q <= '0;
            rx_index_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_index_q <= tx_index_d;
            rx_index_q <= rx_index_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            reload_q   <= reload_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_index_d = tx_index_q;
        rx_index_d = rx_index_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        reload_d   = reload_q;
        rx_we      = 1'b0;
        rx_byte    = {rx_shift_q, mosi_q[2]};
        if (state_q == IDLE) begin
            if (ss_fall) begin
                state_d    = ACTIVE;
                bit_cnt_d  = '0;
                tx_shift_d = tx_buf_q[tx_index_q];
                tx_index_d = tx_index_q + 1'b1;
                reload_d   = 1'b0;
            end
        end else if (ss_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            rx_shift_d = rx_byte[DATA_WIDTH-2:0];
            bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
            if (last_bit) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
                rx_we      = 1'b1;
                rx_index_d = rx_index_q + 1'b1;
                reload_d   = 1'b1;
            end
        end else if (sclk_fall) begin
            tx_shift_d = reload_q ? tx_buf_q[tx_index_q] : tx_shift_q << 1;
            tx_index_d = reload_q ? tx_index_q + 1'b1 : tx_index_q;
            reload_d   = 1'b0;
        end
    end

    // A byte landing at index 0 starts a fresh pass, so the rest of the buffer is wiped.
    always_ff @(posedge clk) begin
        if (reset_on_1) begin
            for (int i = 0; i < DEPTH; i++) rx_buf_q[i] <= '0;
        end else if (rx_we) begin
            for (int i = 1; i < DEPTH; i++) if (rx_index_q == '0) rx_buf_q[i] <= '0;
            rx_buf_q[rx_index_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_wr_en) tx_buf_q[tx_wr_addr] <= tx_wr_data;
    end

    always_ff @(posedge clk) begin
        rd_data_q <= reset_on_1 ? '0 : rx_buf_q[rd_addr];
    end

    assign MISO_SLAVE  = (state_q == ACTIVE) & tx_shift_q[DATA_WIDTH-1];
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_index    = rx_index_q;
    assign is_selected = ~ss_q[1];
    assign rd_data     = rd_data_q;
endmodule
